// File: rtl/hdmi_tx_link_ctrl_pkg.sv
// Shared types and sizing for the HDMI TX link controller: FSM state encoding,
// parameter defaults and counter-width helpers.
package hdmi_tx_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD_RST  = 3'd2,
        ST_ALIGN     = 3'd3,
        ST_RUN       = 3'd4
    } link_state_e;

    localparam int DEF_DATA_WIDTH      = 96;
    localparam int DEF_LOCK_CYCLES     = 1024;
    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_FRAME_TIMEOUT   = 4194304;
    localparam int STAT_CNT_W          = 16;

    // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int LOCK_CNT_W = cnt_width(DEF_LOCK_CYCLES);
    localparam int HOLD_CNT_W = cnt_width(DEF_RST_HOLD_CYCLES);
    localparam int WD_CNT_W   = cnt_width(DEF_FRAME_TIMEOUT);

endpackage

// File: rtl/hdmi_lock_filter.sv
// Qualifies PLL lock and lane clock-stable: emits a one-cycle pulse once both
// have been continuously high for LOCK_CYCLES cycles. Any drop restarts the count.
module hdmi_lock_filter
    import hdmi_tx_link_ctrl_pkg::*;
#(
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic pll_lock,
    input  logic tx_clk_stable,
    output logic qualified
);

    localparam int CW = cnt_width(LOCK_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CYCLES - 1);

    logic [CW-1:0] lock_cnt_reg;
    logic          locked;

    assign locked    = pll_lock & tx_clk_stable;
    // Pulse fires on the cycle the count would reach LOCK_CYCLES.
    assign qualified = locked & ~clear & (lock_cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt_reg <= '0;
        end else if (clear || !locked || qualified) begin
            lock_cnt_reg <= '0;
        end else begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_tx_link_ctrl.sv
// HDMI TX link bring-up controller: waits for qualified lock, holds the video
// pipe in reset, aligns the AXIS stream to start-of-frame, then passes it through.
module hdmi_tx_link_ctrl
    import hdmi_tx_link_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int FRAME_TIMEOUT   = DEF_FRAME_TIMEOUT
) (
    input  logic                  SYS_CLK_I,
    input  logic                  RESET_N_I,
    input  logic                  ENABLE_I,
    input  logic                  PLL_LOCK_I,
    input  logic                  TX_CLK_STABLE_I,
    input  logic [DATA_WIDTH-1:0] S_tdata,
    input  logic                  S_tlast,
    input  logic                  S_tuser,
    input  logic                  S_tvalid,
    output logic                  S_tready_O,
    output logic [DATA_WIDTH-1:0] M_tdata,
    output logic                  M_tlast,
    output logic                  M_tuser,
    output logic                  M_tvalid_O,
    input  logic                  M_tready,
    output logic                  PIPE_RESET_N_O,
    output logic                  LINK_UP_O,
    output logic [2:0]            STATE_O,
    output logic [STAT_CNT_W-1:0] RESYNC_CNT_O,
    output logic [STAT_CNT_W-1:0] FRAME_CNT_O
);

    localparam int HW = cnt_width(RST_HOLD_CYCLES);
    localparam int WW = cnt_width(FRAME_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(FRAME_TIMEOUT - 1);

    link_state_e           state_reg, state_next;
    logic [HW-1:0]         hold_cnt_reg;
    logic [WW-1:0]         wd_cnt_reg;
    logic [STAT_CNT_W-1:0] resync_cnt_reg;
    logic [STAT_CNT_W-1:0] frame_cnt_reg;
    logic                  pipe_rst_n_reg;
    logic                  link_up_reg;
    logic                  resync_inc;
    logic                  locks_ok;
    logic                  lock_qual;
    logic                  sof_hs;

    assign locks_ok = PLL_LOCK_I & TX_CLK_STABLE_I;

    hdmi_lock_filter #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_filter (
        .clk           (SYS_CLK_I),
        .rst_n         (RESET_N_I),
        .clear         (state_reg != ST_WAIT_LOCK),
        .pll_lock      (PLL_LOCK_I),
        .tx_clk_stable (TX_CLK_STABLE_I),
        .qualified     (lock_qual)
    );

    // Sideband is a zero-latency wire; only valid/ready are gated by state.
    assign M_tdata = S_tdata;
    assign M_tlast = S_tlast;
    assign M_tuser = S_tuser;

    always_comb begin
        S_tready_O = 1'b0;
        M_tvalid_O = 1'b0;
        case (state_reg)
            ST_ALIGN: begin
                if (S_tuser) begin
                    M_tvalid_O = S_tvalid;
                    S_tready_O = M_tready;
                end else begin
                    S_tready_O = 1'b1;
                end
            end
            ST_RUN: begin
                M_tvalid_O = S_tvalid;
                S_tready_O = M_tready;
            end
            default: ;
        endcase
    end

    assign sof_hs = M_tvalid_O & M_tready & S_tuser;

    always_comb begin
        state_next = state_reg;
        resync_inc = 1'b0;
        if (state_reg != ST_IDLE && !ENABLE_I) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:      if (ENABLE_I) state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK: if (lock_qual) state_next = ST_HOLD_RST;
                ST_HOLD_RST: begin
                    if (!locks_ok)                    state_next = ST_WAIT_LOCK;
                    else if (hold_cnt_reg == HOLD_LAST) state_next = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!locks_ok)   state_next = ST_WAIT_LOCK;
                    else if (sof_hs) state_next = ST_RUN;
                end
                ST_RUN: begin
                    // A SOF landing on the timeout cycle rescues the frame.
                    if (!locks_ok) begin
                        state_next = ST_WAIT_LOCK;
                        resync_inc = 1'b1;
                    end else if (wd_cnt_reg == WD_LAST && !sof_hs) begin
                        state_next = ST_ALIGN;
                        resync_inc = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK_I) begin
        if (!RESET_N_I) begin
            state_reg      <= ST_IDLE;
            hold_cnt_reg   <= '0;
            wd_cnt_reg     <= '0;
            resync_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
            pipe_rst_n_reg <= 1'b0;
            link_up_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pipe_rst_n_reg <= (state_next == ST_ALIGN) || (state_next == ST_RUN);
            link_up_reg    <= (state_next == ST_RUN);
            hold_cnt_reg   <= (state_reg == ST_HOLD_RST && state_next == ST_HOLD_RST)
                              ? hold_cnt_reg + 1'b1 : '0;
            wd_cnt_reg     <= (state_reg == ST_RUN && state_next == ST_RUN && !sof_hs)
                              ? wd_cnt_reg + 1'b1 : '0;
            if (sof_hs) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (resync_inc && resync_cnt_reg != {STAT_CNT_W{1'b1}}) begin
                resync_cnt_reg <= resync_cnt_reg + 1'b1;
            end
        end
    end

    assign STATE_O        = state_reg;
    assign PIPE_RESET_N_O = pipe_rst_n_reg;
    assign LINK_UP_O      = link_up_reg;
    assign RESYNC_CNT_O   = resync_cnt_reg;
    assign FRAME_CNT_O    = frame_cnt_reg;

endmodule

// File: tb/tb_hdmi_tx_link_ctrl.sv
// Directed bench for hdmi_tx_link_ctrl with short lock/hold/timeout parameters;
// all expected values are hand-derived constants.
module tb_hdmi_tx_link_ctrl;

    localparam int DW = 96;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          pll_lock;
    logic          tx_clk_stable;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          pipe_reset_n;
    logic          link_up;
    logic [2:0]    state;
    logic [15:0]   resync_cnt;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hdmi_tx_link_ctrl #(
        .DATA_WIDTH      (DW),
        .LOCK_CYCLES     (8),
        .RST_HOLD_CYCLES (4),
        .FRAME_TIMEOUT   (100)
    ) dut (
        .SYS_CLK_I       (clk),
        .RESET_N_I       (reset_n),
        .ENABLE_I        (enable),
        .PLL_LOCK_I      (pll_lock),
        .TX_CLK_STABLE_I (tx_clk_stable),
        .S_tdata         (s_tdata),
        .S_tlast         (s_tlast),
        .S_tuser         (s_tuser),
        .S_tvalid        (s_tvalid),
        .S_tready_O      (s_tready),
        .M_tdata         (m_tdata),
        .M_tlast         (m_tlast),
        .M_tuser         (m_tuser),
        .M_tvalid_O      (m_tvalid),
        .M_tready        (m_tready),
        .PIPE_RESET_N_O  (pipe_reset_n),
        .LINK_UP_O       (link_up),
        .STATE_O         (state),
        .RESYNC_CNT_O    (resync_cnt),
        .FRAME_CNT_O     (frame_cnt)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, ~w, w};
    endfunction

    // Starts in IDLE with enable and locks high; ends on the first ALIGN cycle.
    task automatic bring_up(input string tag);
        step();
        check({tag, "_wait_entry"}, DW'(state), DW'(1));
        repeat (7) step();
        check({tag, "_wait_end"}, DW'(state), DW'(1));
        check({tag, "_wait_pipe"}, DW'(pipe_reset_n), DW'(0));
        step();
        check({tag, "_hold_entry"}, DW'(state), DW'(2));
        repeat (3) step();
        check({tag, "_hold_end"}, DW'(state), DW'(2));
        check({tag, "_hold_pipe"}, DW'(pipe_reset_n), DW'(0));
        step();
        check({tag, "_align_entry"}, DW'(state), DW'(3));
        check({tag, "_align_pipe"}, DW'(pipe_reset_n), DW'(1));
        check({tag, "_align_link"}, DW'(link_up), DW'(0));
        $display("tx: %s bring-up reached ALIGN", tag);
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        pll_lock      = 1'b0;
        tx_clk_stable = 1'b0;
        s_tdata       = pat(100);
        s_tlast       = 1'b0;
        s_tuser       = 1'b1;
        s_tvalid      = 1'b1;
        m_tready      = 1'b1;
        step();
        step();
        check("rst_state", DW'(state), DW'(0));
        check("rst_pipe", DW'(pipe_reset_n), DW'(0));
        check("rst_link", DW'(link_up), DW'(0));
        check("rst_tready", DW'(s_tready), DW'(0));
        check("rst_tvalid", DW'(m_tvalid), DW'(0));
        check("rst_resync", DW'(resync_cnt), DW'(0));
        check("rst_frame", DW'(frame_cnt), DW'(0));

        // Bring-up
        reset_n       = 1'b1;
        enable        = 1'b1;
        pll_lock      = 1'b1;
        tx_clk_stable = 1'b1;
        s_tuser       = 1'b0;
        bring_up("bu1");

        // Alignment: non-SOF beats are dropped
        for (int i = 0; i < 5; i++) begin
            s_tdata = pat(i);
            s_tlast = (i == 4);
            #1;
            check("align_drop_tvalid", DW'(m_tvalid), DW'(0));
            check("align_drop_tready", DW'(s_tready), DW'(1));
            check("align_data", m_tdata, pat(i));
            check("align_last", DW'(m_tlast), DW'(i == 4));
            $display("tx: align drop beat %0d data=0x%0h", i, s_tdata);
            step();
        end
        s_tlast = 1'b0;
        s_tuser = 1'b1;
        s_tdata = pat(5);
        #1;
        check("sof_tvalid", DW'(m_tvalid), DW'(1));
        check("sof_tready", DW'(s_tready), DW'(1));
        check("sof_tuser", DW'(m_tuser), DW'(1));
        $display("tx: SOF beat data=0x%0h", s_tdata);
        step();
        check("run_state", DW'(state), DW'(4));
        check("run_link", DW'(link_up), DW'(1));
        check("run_frame", DW'(frame_cnt), DW'(1));

        // Backpressure in RUN
        s_tuser  = 1'b0;
        s_tdata  = pat(6);
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_tready", DW'(s_tready), DW'(0));
            check("bp_tvalid", DW'(m_tvalid), DW'(1));
            check("bp_data", m_tdata, pat(6));
            $display("tx: backpressure cycle %0d", i);
            step();
        end
        m_tready = 1'b1;

        // Watchdog: 100 RUN cycles without SOF
        repeat (96) step();
        check("wd_pre_state", DW'(state), DW'(4));
        check("wd_pre_resync", DW'(resync_cnt), DW'(0));
        step();
        check("wd_state", DW'(state), DW'(3));
        check("wd_resync", DW'(resync_cnt), DW'(1));
        check("wd_link", DW'(link_up), DW'(0));
        check("wd_pipe", DW'(pipe_reset_n), DW'(1));
        $display("tx: watchdog timeout to ALIGN");

        // Timeout coinciding with a SOF handshake
        s_tuser = 1'b1;
        step();
        check("realign_state", DW'(state), DW'(4));
        check("realign_frame", DW'(frame_cnt), DW'(2));
        s_tuser = 1'b0;
        repeat (99) step();
        s_tuser = 1'b1;
        step();
        s_tuser = 1'b0;
        check("wd_sof_state", DW'(state), DW'(4));
        check("wd_sof_resync", DW'(resync_cnt), DW'(1));
        check("wd_sof_frame", DW'(frame_cnt), DW'(3));
        $display("tx: SOF on timeout cycle kept RUN");

        // Lock glitch in RUN, then lock count restart inside WAIT_LOCK
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        #1;
        check("glitch_state", DW'(state), DW'(1));
        check("glitch_pipe", DW'(pipe_reset_n), DW'(0));
        check("glitch_link", DW'(link_up), DW'(0));
        check("glitch_resync", DW'(resync_cnt), DW'(2));
        check("glitch_tready", DW'(s_tready), DW'(0));
        check("glitch_tvalid", DW'(m_tvalid), DW'(0));
        repeat (4) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        repeat (7) step();
        check("relock_restart", DW'(state), DW'(1));
        step();
        check("relock_hold", DW'(state), DW'(2));
        repeat (4) step();
        check("relock_align", DW'(state), DW'(3));
        s_tuser = 1'b1;
        step();
        s_tuser = 1'b0;
        check("relock_run", DW'(state), DW'(4));
        check("relock_frame", DW'(frame_cnt), DW'(4));
        $display("tx: relocked and back in RUN");

        // Disable and lock loss together: disable wins
        enable   = 1'b0;
        pll_lock = 1'b0;
        step();
        check("prio_state", DW'(state), DW'(0));
        check("prio_resync", DW'(resync_cnt), DW'(2));
        check("prio_pipe", DW'(pipe_reset_n), DW'(0));
        check("prio_link", DW'(link_up), DW'(0));
        $display("tx: disable with lock loss to IDLE");

        // Back to RUN, then reset mid-frame
        enable   = 1'b1;
        pll_lock = 1'b1;
        bring_up("bu2");
        s_tuser = 1'b1;
        step();
        check("bu2_run", DW'(state), DW'(4));
        check("bu2_frame", DW'(frame_cnt), DW'(5));
        s_tuser  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = pat(7);
        reset_n  = 1'b0;
        step();
        check("mid_rst_state", DW'(state), DW'(0));
        check("mid_rst_pipe", DW'(pipe_reset_n), DW'(0));
        check("mid_rst_link", DW'(link_up), DW'(0));
        check("mid_rst_tready", DW'(s_tready), DW'(0));
        check("mid_rst_tvalid", DW'(m_tvalid), DW'(0));
        check("mid_rst_resync", DW'(resync_cnt), DW'(0));
        check("mid_rst_frame", DW'(frame_cnt), DW'(0));
        $display("tx: reset during RUN");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_tx_link_ctrl.md
HDMI_TX_LINK_CTRL -- requirements
Module: hdmi_tx_link_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, giving the AXIS tdata width (4 pixels/clk x 24 bit).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 1024, giving the cycles of continuous lock required before bring-up.
REQ-003 The block SHALL have parameter RST_HOLD_CYCLES, default 16, giving the cycles the video pipe reset is held after lock qualifies.
REQ-004 The block SHALL have parameter FRAME_TIMEOUT, default 4194304, giving the maximum cycles between start-of-frame beats in RUN.
REQ-005 The block SHALL have the following ports (name  direction  width  meaning):
- SYS_CLK_I  in  1  single clock, the transceiver TX_CLK_R domain.
- RESET_N_I  in  1  synchronous active-low reset.
- ENABLE_I  in  1  link enable.
- PLL_LOCK_I  in  1  TX PLL lock.
- TX_CLK_STABLE_I  in  1  lane TX clock stable.
- S_tdata/S_tlast/S_tuser/S_tvalid  in  DATA_WIDTH/1/1/1  upstream video stream.
- S_tready_O  out  1  upstream ready.
- M_tdata/M_tlast/M_tuser/M_tvalid_O  out  DATA_WIDTH/1/1/1  stream to the AXIS-to-VGA converter.
- M_tready  in  1  converter ready.
- PIPE_RESET_N_O  out  1  registered active-low reset to the converter and TMDS encoder.
- LINK_UP_O  out  1  high in RUN.
- STATE_O  out  3  current state encoding.
- RESYNC_CNT_O  out  16  saturating resync count.
- FRAME_CNT_O  out  16  wrapping count of forwarded SOF beats.

Function
REQ-006 The FSM SHALL have states IDLE=0, WAIT_LOCK=1, HOLD_RST=2, ALIGN=3, RUN=4.
REQ-007 In IDLE, the FSM SHALL go to WAIT_LOCK when ENABLE_I=1.
REQ-008 In WAIT_LOCK, a lock counter SHALL increment while PLL_LOCK_I and TX_CLK_STABLE_I are both 1, clear when either is 0, and move the FSM to HOLD_RST on the cycle the count reaches LOCK_CYCLES.
REQ-009 In HOLD_RST, the FSM SHALL count RST_HOLD_CYCLES cycles and then go to ALIGN.
REQ-010 PIPE_RESET_N_O SHALL be 0 in IDLE, WAIT_LOCK and HOLD_RST, and 1 in ALIGN and RUN, registered with no combinational path from the inputs.
REQ-011 In IDLE, WAIT_LOCK and HOLD_RST, S_tready_O SHALL be 0 and M_tvalid_O SHALL be 0.
REQ-012 In ALIGN, beats with S_tuser=0 SHALL be dropped: S_tready_O=1, M_tvalid_O=0.
REQ-013 In ALIGN, when S_tvalid=1 and S_tuser=1, the beat SHALL pass through (M_tvalid_O=1, S_tready_O=M_tready), and the FSM SHALL go to RUN on the cycle that beat handshakes.
REQ-014 In RUN, the block SHALL be a combinational pass-through: M_tvalid_O=S_tvalid, S_tready_O=M_tready.
REQ-015 M_tdata, M_tlast and M_tuser SHALL always equal S_tdata, S_tlast and S_tuser with zero latency.
REQ-016 In RUN, a frame watchdog SHALL clear on each handshaked SOF beat and otherwise increment; on reaching FRAME_TIMEOUT the FSM SHALL go to ALIGN and RESYNC_CNT_O SHALL increment.
REQ-017 In any state except IDLE, ENABLE_I=0 SHALL force IDLE on the next cycle.
REQ-018 In HOLD_RST, ALIGN and RUN, PLL_LOCK_I=0 or TX_CLK_STABLE_I=0 SHALL force WAIT_LOCK with counters cleared, and RESYNC_CNT_O SHALL increment if the state was RUN.
REQ-019 Transition priority SHALL be: disable > lock loss > watchdog timeout > normal transition.
REQ-020 FRAME_CNT_O SHALL increment on every handshaked M_tuser=1 beat and wrap at 0xFFFF->0.
REQ-021 RESYNC_CNT_O SHALL saturate at 0xFFFF.
REQ-022 A timeout coinciding with a SOF handshake SHALL be treated as a SOF: the watchdog clears and no resync occurs.
REQ-023 LINK_UP_O SHALL equal (STATE_O==RUN), registered.

Reset
REQ-024 On RESET_N_I=0 at a clock edge, the block SHALL enter IDLE with all counters 0, PIPE_RESET_N_O=0, LINK_UP_O=0, STATE_O=0, S_tready_O=0 and M_tvalid_O=0.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge, and any in-flight beat SHALL be abandoned.

Structure
REQ-026 Package hdmi_tx_link_ctrl_pkg SHALL hold the state enum, the counter widths (lock, hold and watchdog via clog2) and the parameter defaults.
REQ-027 The lock qualifier SHALL be a sub-module hdmi_lock_filter: inputs are the two lock bits, the output is a one-cycle qualified pulse, and it has a clear input.

Verification
REQ-028 Bring-up, LOCK_CYCLES=8, RST_HOLD_CYCLES=4: ENABLE=1 and locks=1 -> HOLD_RST after 8 lock cycles, ALIGN 4 cycles later, PIPE_RESET_N_O rises entering ALIGN.
REQ-029 Alignment: 5 beats with tuser=0 then a SOF beat -> 5 beats dropped with M_tvalid_O=0, SOF forwarded, RUN entered, FRAME_CNT_O=1.
REQ-030 Backpressure: in RUN hold M_tready=0 for 3 cycles -> S_tready_O=0 and the data is held unchanged at M.
REQ-031 Watchdog, FRAME_TIMEOUT=100: no SOF for 100 cycles -> ALIGN, RESYNC_CNT_O=1, LINK_UP_O falls.
REQ-032 Lock glitch: drop PLL_LOCK_I for 1 cycle in RUN -> WAIT_LOCK, PIPE_RESET_N_O=0, and the lock count restarts from 0.
REQ-033 Priority: deassert ENABLE_I and drop lock in the same cycle -> IDLE; reset during RUN -> all outputs return to their reset values.
